// File: rtl/n0_inv.sv
// Computes nprime0 = -n0^-1 mod 2^64 for Montgomery reduction, one bit per cycle.
// An even n0 has no inverse; it finishes at once with err set and nprime0 zero.
module n0_inv (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        go,
   input  logic [63:0] n0,
   output logic [63:0] nprime0,
   output logic        valid,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] n_q;
   logic [63:0] acc, acc_nxt;
   logic [63:0] x, x_nxt;
   logic [6:0]  i;

   // Bit i of acc is final once step i is done: adding n<<i (n odd) sets it and
   // leaves lower bits alone, so acc ends all ones and x is -n^-1.
   always_comb begin
      acc_nxt = acc;
      x_nxt   = x;
      if (!acc[i[5:0]]) begin
         acc_nxt        = acc + (n_q << i[5:0]);
         x_nxt[i[5:0]]  = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = n0[0] ? RUN : DONE;
         RUN:     if (i == 7'd63) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the datapath registers are small, so they are cleared on reset along
   // with the control state; all sequential state uses non-blocking assignments.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         n_q     <= '0;
         acc     <= '0;
         x       <= '0;
         i       <= '0;
         nprime0 <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (go) begin
                  n_q <= n0;
                  acc <= '0;
                  x   <= '0;
                  i   <= '0;
                  if (!n0[0]) begin
                     nprime0 <= '0;
                     err     <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc <= acc_nxt;
               x   <= x_nxt;
               i   <= i + 7'd1;
               if (i == 7'd63) begin
                  nprime0 <= x_nxt;
                  err     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid = (state == DONE);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_n0_inv.sv
// Self-checking bench for n0_inv: directed corner cases plus random odd operands
// compared against a Newton-iteration inverse model.
module tb_n0_inv;

   logic        clk;
   logic        reset_n;
   logic        go;
   logic [63:0] n0;
   logic [63:0] nprime0;
   logic        valid;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   n0_inv dut (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go),
      .n0      (n0),
      .nprime0 (nprime0),
      .valid   (valid),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Newton iteration: inv*n == 1 mod 8 for odd n, precision doubles each pass.
   function automatic logic [63:0] ref_nprime(input logic [63:0] n);
      logic [63:0] inv;
      if (!n[0]) return 64'd0;
      inv = n;
      for (int k = 0; k < 6; k++) inv = inv * (64'd2 - n * inv);
      return -inv;
   endfunction

   // Raise go for one edge and wait for valid; lat counts edges from the edge
   // after which go was raised. post_vb samples {valid,busy} one cycle later.
   task automatic run_op(input logic [63:0] v, output logic [63:0] res, output logic e,
                         output int lat, output logic busy_all, output logic [1:0] post_vb);
      @(negedge clk);
      go = 1'b1;
      n0 = v;
      lat = 0;
      busy_all = 1'b1;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         go = 1'b0;
         busy_all &= busy;
         if (valid) break;
      end
      res = nprime0;
      e   = err;
      @(negedge clk);
      post_vb = {valid, busy};
   endtask

   initial begin
      logic [63:0] res, v, a, b;
      logic        e, busy_all, seen_valid;
      logic [1:0]  post_vb;
      int          lat;

      reset_n = 1'b1;
      go      = 1'b0;
      n0      = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_nprime0", nprime0, 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      reset_n = 1'b1;

      // n0 = 3
      run_op(64'd3, res, e, lat, busy_all, post_vb);
      check("n3_result", res, 64'h5555_5555_5555_5555);
      check("n3_err", 64'(e), 64'd0);
      check("n3_latency", 64'(lat), 64'd65);
      check("n3_busy_during", 64'(busy_all), 64'd1);
      check("n3_after_valid_busy", 64'(post_vb), 64'd0);

      run_op(64'd1, res, e, lat, busy_all, post_vb);
      check("n1_result", res, ALL_ONES);
      run_op(ALL_ONES, res, e, lat, busy_all, post_vb);
      check("nmax_result", res, 64'd1);
      run_op(64'd77, res, e, lat, busy_all, post_vb);
      check("n77_result", res, ref_nprime(64'd77));
      check("n77_product", 64'd77 * res, ALL_ONES);

      for (int t = 0; t < 1000; t++) begin
         v = {$urandom, $urandom} | 64'd1;
         run_op(v, res, e, lat, busy_all, post_vb);
         check("rand_product", v * res, ALL_ONES);
         check("rand_model", res, ref_nprime(v));
         check("rand_err", 64'(e), 64'd0);
      end

      // Even operand: immediate DONE with err.
      run_op(64'h10, res, e, lat, busy_all, post_vb);
      check("even_latency", 64'(lat), 64'd1);
      check("even_err", 64'(e), 64'd1);
      check("even_result", res, 64'd0);
      check("even_busy_during", 64'(busy_all), 64'd1);
      check("even_after_valid", 64'(post_vb), 64'd0);

      // go held high, n0 changed mid-run.
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'hFEDC_BA98_7654_3211;
      @(negedge clk);
      go  = 1'b1;
      n0  = a;
      lat = 0;
      seen_valid = 1'b0;
      while (lat < 200 && !seen_valid) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 10) begin
            n0 = b;
            check("hold_busy_mid", 64'(busy), 64'd1);
            check("hold_err_stable", 64'(err), 64'd1);
            check("hold_np_stable", nprime0, 64'd0);
         end
         seen_valid = valid;
      end
      check("hold_latency", 64'(lat), 64'd65);
      check("hold_result_a", nprime0, ref_nprime(a));
      @(negedge clk);
      check("hold_idle_gap", 64'({valid, busy}), 64'd0);
      @(negedge clk);
      check("hold_restart_busy", 64'(busy), 64'd1);
      go  = 1'b0;
      lat = 2;
      seen_valid = 1'b0;
      while (lat < 200 && !seen_valid) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 20) check("hold_np_kept", nprime0, ref_nprime(a));
         seen_valid = valid;
      end
      check("hold_second_gap", 64'(lat), 64'd66);
      check("hold_result_b", nprime0, ref_nprime(b));

      // Reset mid-run at RUN cycle 30.
      @(negedge clk);
      go = 1'b1;
      n0 = 64'd5;
      @(posedge clk);
      #1 go = 1'b0;
      repeat (30) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_nprime0", nprime0, 64'd0);
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      seen_valid = 1'b0;
      repeat (80) begin
         @(negedge clk);
         seen_valid |= valid;
      end
      check("midrst_no_valid", 64'(seen_valid), 64'd0);
      run_op(64'd3, res, e, lat, busy_all, post_vb);
      check("midrst_new_result", res, 64'h5555_5555_5555_5555);
      check("midrst_new_latency", 64'(lat), 64'd65);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
